// File: rtl/ravenna_flash_gpio.sv
// ravenna_flash_gpio: boot-time sequencer that streams halfwords from an SPI
// flash (continuous read, command 0x03) onto a 16-bit GPIO port, holding each
// halfword for HOLD_CYCLES clocks, then parks with done=1.
// Optional feature macro: RAVENNA_FLASH_WAKE_EN adds a 0xAB release-from-
// power-down transfer followed by a 4-cycle chip-select-high gap before CMD.
module ravenna_flash_gpio #(
    parameter int          CLK_DIV     = 2,
    parameter logic [23:0] START_ADDR  = 24'h000000,
    parameter int          NUM_WORDS   = 4,
    parameter int          HOLD_CYCLES = 16
) (
    input  logic        XCLK,
    input  logic        reset,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1,
    output logic [15:0] gpio,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
`ifdef RAVENNA_FLASH_WAKE_EN
        WAKE,
        WGAP,
`endif
        CMD,
        ADDR,
        DATA,
        HOLD,
        DONE
    } state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] WORDS     = 16'(NUM_WORDS);
    localparam logic [31:0] TX_READ   = {8'h03, START_ADDR};
`ifdef RAVENNA_FLASH_WAKE_EN
    localparam logic [31:0] TX_WAKE   = {8'hAB, 24'h000000};
`endif
    // With a one-cycle half period there is no spare low cycle after the
    // falling edge, so MOSI is launched on the falling edge itself.
    localparam bit EARLY = (CLK_DIV == 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [31:0] tx_sr;
    logic [15:0] rx_sr;
    logic [15:0] hold_cnt;
    logic [15:0] word_cnt;

    logic        shifting;
    logic [4:0]  bit_last;
    logic        half_end;
    logic        rise;
    logic        fall;

    // Which states run the serial clock and how many bits each transfers
    always_comb begin
        shifting = 1'b0;
        bit_last = 5'd7;
        case (state)
`ifdef RAVENNA_FLASH_WAKE_EN
            WAKE: shifting = 1'b1;
`endif
            CMD:  shifting = 1'b1;
            ADDR: begin
                shifting = 1'b1;
                bit_last = 5'd23;
            end
            DATA: begin
                shifting = 1'b1;
                bit_last = 5'd15;
            end
            default: ;
        endcase
    end

    assign half_end = shifting && (div_cnt == DIV_LAST);
    assign rise     = half_end && !flash_clk;
    assign fall     = half_end && flash_clk;

    // Sequencer FSM with serial engine; every output is a register
    always_ff @(posedge XCLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            flash_csb <= 1'b1;
            flash_clk <= 1'b0;
            flash_io0 <= 1'b0;
            gpio      <= 16'h0000;
            done      <= 1'b0;
            div_cnt   <= 8'd0;
            bit_cnt   <= 5'd0;
            tx_sr     <= 32'd0;
            rx_sr     <= 16'd0;
            hold_cnt  <= 16'd0;
            word_cnt  <= 16'd0;
        end else begin
            // Half-period divider shared by all shifting states
            if (shifting) begin
                if (half_end) begin
                    div_cnt   <= 8'd0;
                    flash_clk <= ~flash_clk;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    flash_csb <= 1'b0;
                    flash_clk <= 1'b0;
                    div_cnt   <= 8'd0;
                    bit_cnt   <= 5'd0;
`ifdef RAVENNA_FLASH_WAKE_EN
                    state     <= WAKE;
                    tx_sr     <= TX_WAKE;
                    flash_io0 <= EARLY ? TX_WAKE[31] : 1'b0;
`else
                    state     <= CMD;
                    tx_sr     <= TX_READ;
                    flash_io0 <= EARLY ? TX_READ[31] : 1'b0;
`endif
                end

`ifdef RAVENNA_FLASH_WAKE_EN
                WGAP: begin
                    if (hold_cnt == 16'd3) begin
                        hold_cnt  <= 16'd0;
                        state     <= CMD;
                        flash_csb <= 1'b0;
                        div_cnt   <= 8'd0;
                        bit_cnt   <= 5'd0;
                        tx_sr     <= TX_READ;
                        flash_io0 <= EARLY ? TX_READ[31] : 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end

                WAKE,
`endif
                CMD, ADDR: begin
                    // MOSI launched on the first low cycle of each bit
                    if (!EARLY && !flash_clk && (div_cnt == 8'd0))
                        flash_io0 <= tx_sr[31];
                    if (fall) begin
                        tx_sr <= {tx_sr[30:0], 1'b0};
                        if (EARLY)
                            flash_io0 <= tx_sr[30];
                        if (bit_cnt == bit_last) begin
                            bit_cnt <= 5'd0;
                            if (state == ADDR) begin
                                state     <= DATA;
                                flash_io0 <= 1'b0;
                            end
`ifdef RAVENNA_FLASH_WAKE_EN
                            else if (state == WAKE) begin
                                state     <= WGAP;
                                flash_csb <= 1'b1;
                                flash_io0 <= 1'b0;
                                hold_cnt  <= 16'd0;
                            end
`endif
                            else begin
                                state <= ADDR;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                DATA: begin
                    if (rise)
                        rx_sr <= {rx_sr[14:0], flash_io1};
                    if (fall) begin
                        if (bit_cnt == bit_last) begin
                            bit_cnt  <= 5'd0;
                            hold_cnt <= 16'd0;
                            word_cnt <= word_cnt + 16'd1;
                            state    <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                HOLD: begin
                    // First byte off the wire is the low byte
                    if (hold_cnt == 16'd0)
                        gpio <= {rx_sr[7:0], rx_sr[15:8]};
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= 16'd0;
                        div_cnt  <= 8'd0;
                        if (word_cnt < WORDS) begin
                            state <= DATA;
                        end else begin
                            state     <= DONE;
                            flash_csb <= 1'b1;
                            done      <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end

                DONE: ;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ravenna_flash_gpio.sv
// Testbench for ravenna_flash_gpio: three instances (defaults, START_ADDR=4
// with one word, CLK_DIV=1) each talking to a small behavioural SPI flash.
module tb_ravenna_flash_gpio;

    logic        xclk;
    logic        rst;
    logic        f_csb  [3];
    logic        f_clk  [3];
    logic        f_io0  [3];
    logic        f_io1  [3];
    logic        f_done [3];
    logic [15:0] f_gpio [3];

    int cyc;
    int checks;
    int failures;

    logic [7:0] flash_mem [8] = '{8'h34, 8'h12, 8'h78, 8'h56,
                                  8'hBC, 8'h9A, 8'hF0, 8'hDE};
    logic [15:0] exp_words [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

`ifdef RAVENNA_FLASH_WAKE_EN
    localparam int LAT0 = 230;
    localparam int LAT2 = 118;
`else
    localparam int LAT0 = 194;
    localparam int LAT2 = 98;
`endif

    ravenna_flash_gpio dut0 (
        .XCLK(xclk), .reset(rst), .flash_csb(f_csb[0]), .flash_clk(f_clk[0]),
        .flash_io0(f_io0[0]), .flash_io1(f_io1[0]), .gpio(f_gpio[0]), .done(f_done[0])
    );

    ravenna_flash_gpio #(.START_ADDR(24'h000004), .NUM_WORDS(1)) dut1 (
        .XCLK(xclk), .reset(rst), .flash_csb(f_csb[1]), .flash_clk(f_clk[1]),
        .flash_io0(f_io0[1]), .flash_io1(f_io1[1]), .gpio(f_gpio[1]), .done(f_done[1])
    );

    ravenna_flash_gpio #(.CLK_DIV(1)) dut2 (
        .XCLK(xclk), .reset(rst), .flash_csb(f_csb[2]), .flash_clk(f_clk[2]),
        .flash_io0(f_io0[2]), .flash_io1(f_io1[2]), .gpio(f_gpio[2]), .done(f_done[2])
    );

    initial xclk = 1'b0;
    always #5 xclk = ~xclk;

    // Cycle count since reset release: edge N after release sees cyc == N
    always @(posedge xclk) begin
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
    end

    function automatic logic mem_bit(int p);
        logic [7:0] b;
        b = flash_mem[(p / 8) % 8];
        return b[7 - (p % 8)];
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s value=%h", tag, got);
        end
    endtask

    // Flash model and observer per instance, evaluated mid-cycle
    for (genvar gi = 0; gi < 3; gi++) begin : g_flash
        int          bit_n;
        int          rd_ptr;
        int          hi_cnt;
        int          rise_n;
        int          last_rise;
        int          first_gap;
        logic [31:0] hdr;
        logic        clk_prev;
        logic        csb_prev;
        logic        io1_r;
        logic [15:0] gpio_prev;
        logic [7:0]  cmd_q  [$];
        logic [23:0] addr_q [$];
        int          gap_q  [$];
        logic [15:0] chg_q  [$];
        int          stamp_q[$];

        assign f_io1[gi] = io1_r;

        always @(negedge xclk) begin
            if (rst) begin
                bit_n = 0; rd_ptr = 0; hi_cnt = 0; rise_n = 0;
                last_rise = 0; first_gap = 0; hdr = 0;
                clk_prev = 1'b0; csb_prev = 1'b1; io1_r = 1'b0;
                gpio_prev = 16'h0000;
                cmd_q.delete(); addr_q.delete(); gap_q.delete();
                chg_q.delete(); stamp_q.delete();
            end else begin
                if (f_gpio[gi] != gpio_prev) begin
                    chg_q.push_back(f_gpio[gi]);
                    stamp_q.push_back(cyc);
                    gpio_prev = f_gpio[gi];
                end
                if (f_csb[gi]) begin
                    if (!csb_prev) hi_cnt = 0;
                    hi_cnt++;
                    bit_n = 0;
                end else begin
                    if (csb_prev) gap_q.push_back(hi_cnt);
                    if (f_clk[gi] && !clk_prev) begin
                        rise_n++;
                        if (rise_n == 1) last_rise = cyc;
                        if (rise_n == 2) first_gap = cyc - last_rise;
                        if (bit_n < 32) begin
                            hdr = {hdr[30:0], f_io0[gi]};
                            bit_n++;
                            if (bit_n == 8) cmd_q.push_back(hdr[7:0]);
                            if (bit_n == 32) begin
                                addr_q.push_back(hdr[23:0]);
                                rd_ptr = int'(hdr[23:0]) * 8;
                            end
                        end
                    end
                    if (!f_clk[gi] && clk_prev && bit_n >= 32) begin
                        io1_r = mem_bit(rd_ptr);
                        rd_ptr++;
                    end
                end
                clk_prev = f_clk[gi];
                csb_prev = f_csb[gi];
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        repeat (3) @(posedge xclk);
        @(negedge xclk);
        check("rst_csb",  32'(f_csb[0]),  32'd1);
        check("rst_clk",  32'(f_clk[0]),  32'd0);
        check("rst_io0",  32'(f_io0[0]),  32'd0);
        check("rst_gpio", 32'(f_gpio[0]), 32'h0);
        check("rst_done", 32'(f_done[0]), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 3000 && !(f_done[0] && f_done[1] && f_done[2]); i++)
            @(negedge xclk);
        check("done0", 32'(f_done[0]), 32'd1);
        check("done1", 32'(f_done[1]), 32'd1);
        check("done2", 32'(f_done[2]), 32'd1);

        // Default instance: words, latency, spacing, headers, park state
        check("nwords0", 32'(g_flash[0].chg_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < g_flash[0].chg_q.size(); i++)
            check($sformatf("word0_%0d", i), 32'(g_flash[0].chg_q[i]), 32'(exp_words[i]));
        if (g_flash[0].stamp_q.size() > 0)
            check("lat0", 32'(g_flash[0].stamp_q[0]), 32'(LAT0));
        for (int i = 1; i < g_flash[0].stamp_q.size(); i++)
            check($sformatf("space0_%0d", i),
                  32'(g_flash[0].stamp_q[i] - g_flash[0].stamp_q[i-1]), 32'd80);
`ifdef RAVENNA_FLASH_WAKE_EN
        check("cmd0_wake", 32'(g_flash[0].cmd_q[0]), 32'hAB);
        check("cmd0_read", 32'(g_flash[0].cmd_q[1]), 32'h03);
        check("wgap0",     32'(g_flash[0].gap_q[1]), 32'd4);
`else
        check("cmd0_read", 32'(g_flash[0].cmd_q[0]), 32'h03);
`endif
        check("addr0",     32'(g_flash[0].addr_q[0]), 32'h000000);
        check("sclk_per0", 32'(g_flash[0].first_gap), 32'd4);
        check("park_csb0", 32'(f_csb[0]),  32'd1);
        check("park_io00", 32'(f_io0[0]),  32'd0);
        check("park_gpio0", 32'(f_gpio[0]), 32'hDEF0);

        // START_ADDR=4, NUM_WORDS=1
        check("nwords1", 32'(g_flash[1].chg_q.size()), 32'd1);
        check("word1_0", 32'(g_flash[1].chg_q[0]), 32'h9ABC);
        check("lat1",    32'(g_flash[1].stamp_q[0]), 32'(LAT0));
        check("addr1",   32'(g_flash[1].addr_q[0]), 32'h000004);
        check("park_csb1", 32'(f_csb[1]), 32'd1);

        // CLK_DIV=1
        check("nwords2", 32'(g_flash[2].chg_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < g_flash[2].chg_q.size(); i++)
            check($sformatf("word2_%0d", i), 32'(g_flash[2].chg_q[i]), 32'(exp_words[i]));
        check("lat2",      32'(g_flash[2].stamp_q[0]), 32'(LAT2));
        if (g_flash[2].stamp_q.size() > 1)
            check("space2_1", 32'(g_flash[2].stamp_q[1] - g_flash[2].stamp_q[0]), 32'd48);
        check("sclk_per2", 32'(g_flash[2].first_gap), 32'd2);

        // Restart, then hit reset in the middle of the second DATA phase
        @(negedge xclk);
        rst = 1'b1;
        repeat (2) @(negedge xclk);
        rst = 1'b0;
        for (int i = 0; i < 1000 && cyc < LAT0 + 40; i++)
            @(negedge xclk);
        check("mid_gpio_pre", 32'(f_gpio[0]), 32'h1234);
        check("mid_csb_pre",  32'(f_csb[0]),  32'd0);
        @(posedge xclk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_gpio_rst", 32'(f_gpio[0]), 32'h0);
        check("mid_csb_rst",  32'(f_csb[0]),  32'd1);
        check("mid_clk_rst",  32'(f_clk[0]),  32'd0);
        check("mid_done_rst", 32'(f_done[0]), 32'd0);
        repeat (2) @(negedge xclk);
        rst = 1'b0;
        for (int i = 0; i < 1000 && g_flash[0].chg_q.size() == 0; i++)
            @(negedge xclk);
        check("restart_n", 32'(g_flash[0].chg_q.size() > 0), 32'd1);
        if (g_flash[0].chg_q.size() > 0) begin
            check("restart_word", 32'(g_flash[0].chg_q[0]), 32'h1234);
            check("restart_lat",  32'(g_flash[0].stamp_q[0]), 32'(LAT0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
